if_fetch_unit: RTL and testbench

- Instruction fetch front end; the producer side of the IF/ID pipeline register.
- Holds the fetch PC and issues word requests on a pipelined instruction bus (req/gnt address phase, rvalid data phase).
- Buffers returned words with their PCs in a small prefetch FIFO and presents one {pc, inst} pair per cycle to IF/ID.
- Handles branch redirects from EX (flush plus discard of stale responses) and IF/ID stalls from ctrl.

---
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: issues pipelined word fetches, buffers returned words with
// their PCs in a small prefetch FIFO, and hands one {pc, inst} pair per cycle to IF/ID.
module if_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_branch_flag_i,
    input  logic [31:0] ex_branch_addr_i,
    input  logic [4:0]  stalled_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];

    logic [CW:0]   inflight;
    logic          credit_ok;
    logic          fire;
    logic          drop;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;
    logic          unused_ok;

    assign unused_ok = ^{stalled_i[4:2], stalled_i[0], ex_branch_addr_i[1:0]};

    always_comb begin
        inflight    = {1'b0, count_q} + {1'b0, outstanding_q};
        credit_ok   = inflight < (CW + 1)'(DEPTH);
        ibus_req_o  = !rst && !ex_branch_flag_i && credit_ok;
        ibus_addr_o = {fetch_pc_q[31:2], 2'b00};
        fire        = ibus_req_o && ibus_gnt_i;
        drop        = ibus_rvalid_i && (discard_q != '0);
        push        = ibus_rvalid_i && (discard_q == '0) && !ex_branch_flag_i;
        valid_o     = !rst && (count_q != '0) && !ex_branch_flag_i;
        pop         = valid_o && !stalled_i[1];
        target_pc   = {ex_branch_addr_i[31:2], 2'b00};
        pc_o        = valid_o ? fifo_pc_q[rd_ptr_q]   : '0;
        inst_o      = valid_o ? fifo_inst_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            case ({fire, ibus_rvalid_i})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase

            if (ex_branch_flag_i) begin
                fetch_pc_q <= target_pc;
                resp_pc_q  <= target_pc;
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                // outstanding already includes responses still marked for discard, so every
                // in-flight word becomes stale exactly once (no double count on back-to-back).
                discard_q  <= outstanding_q - CW'(ibus_rvalid_i);
            end else begin
                if (fire) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (drop) begin
                    discard_q <= discard_q - 1'b1;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
            fifo_inst_q[wr_ptr_q] <= ibus_rdata_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop) |-> (count_q < CW'(DEPTH)));

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        ibus_rvalid_i |-> (outstanding_q != '0));

    a_discard_bounded: assert property (@(posedge clk) disable iff (rst)
        discard_q <= CW'(DEPTH));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with an in-order bus responder of configurable latency.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_branch_flag_i;
    logic [31:0] ex_branch_addr_i;
    logic [4:0]  stalled_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_branch_flag_i (ex_branch_flag_i),
        .ex_branch_addr_i (ex_branch_addr_i),
        .stalled_i        (stalled_i),
        .ibus_req_o       (ibus_req_o),
        .ibus_addr_o      (ibus_addr_o),
        .ibus_gnt_i       (ibus_gnt_i),
        .ibus_rvalid_i    (ibus_rvalid_i),
        .ibus_rdata_i     (ibus_rdata_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .valid_o          (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc;
    int          resp_lat;
    resp_t       pend[$];
    logic [31:0] iss_q[$];
    logic [31:0] dpc_q[$];
    logic [31:0] dinst_q[$];
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    // One clock cycle: sample mid-cycle, then drive the bus response for the next cycle.
    task automatic tick();
        @(negedge clk);
        s_req   = ibus_req_o;
        s_addr  = ibus_addr_o;
        s_valid = valid_o;
        s_pc    = pc_o;
        s_inst  = inst_o;
        if (s_req && ibus_gnt_i) begin
            pend.push_back('{addr: s_addr, due: cyc + resp_lat});
            iss_q.push_back(s_addr);
        end
        if (s_valid) begin
            dpc_q.push_back(s_pc);
            dinst_q.push_back(s_inst);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = pend[0].addr ^ 32'hA5A5_0000;
            void'(pend.pop_front());
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = '0;
        end
    endtask

    task automatic do_reset(input int lat, input logic gnt);
        rst              = 1'b1;
        ex_branch_flag_i = 1'b0;
        ex_branch_addr_i = '0;
        stalled_i        = '0;
        ibus_gnt_i       = gnt;
        ibus_rvalid_i    = 1'b0;
        ibus_rdata_i     = '0;
        resp_lat         = lat;
        pend.delete();
        iss_q.delete();
        dpc_q.delete();
        dinst_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
    endtask

    task automatic clear_logs();
        iss_q.delete();
        dpc_q.delete();
        dinst_q.delete();
    endtask

    task automatic test_reset();
        do_reset(1, 1'b1);
        rst = 1'b1;
        #2;
        n_checks++;
        if ({ibus_req_o, valid_o, pc_o, inst_o} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b valid=%b pc=%h inst=%h, required all zero",
                     ibus_req_o, valid_o, pc_o, inst_o);
        end
        do_reset(1, 1'b1);
        repeat (4) tick();
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ibus_req_o, valid_o, pc_o, inst_o} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b valid=%b pc=%h inst=%h, required all zero",
                     ibus_req_o, valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_stream();
        do_reset(1, 1'b1);
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_c1: req=%b addr=%h valid=%b, required 1 00000000 0", s_req, s_addr, s_valid);
        end
        tick();
        n_checks++;
        if (s_addr !== 32'h4 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_c2: addr=%h valid=%b, required 00000004 0", s_addr, s_valid);
        end
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_inst !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL stream_first: valid=%b pc=%h inst=%h, required 1 00000000 a5a50000",
                     s_valid, s_pc, s_inst);
        end
        repeat (20) tick();
        n_checks++;
        if (dpc_q.size() != 14) begin
            n_fail++;
            $display("FAIL stream_count: delivered %0d words, required 14", dpc_q.size());
        end
        for (int i = 0; i < dpc_q.size(); i++) begin
            n_checks++;
            if (dpc_q[i] !== 32'(4 * i) || dinst_q[i] !== (32'(4 * i) ^ 32'hA5A5_0000)) begin
                n_fail++;
                $display("FAIL stream_word[%0d]: pc=%h inst=%h, required %h %h", i, dpc_q[i], dinst_q[i],
                         32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000);
            end
        end
        for (int i = 0; i < iss_q.size(); i++) begin
            n_checks++;
            if (iss_q[i] !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_addr[%0d]: addr=%h, required %h", i, iss_q[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1, 1'b1);
        repeat (6) tick();
        stalled_i = 5'b00010;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (s_valid !== 1'b1 || s_pc !== 32'hC) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h, required 1 0000000c", k, s_valid, s_pc);
            end
            n_checks++;
            if (s_req !== (k == 0)) begin
                n_fail++;
                $display("FAIL stall_req[%0d]: req=%b, required %b", k, s_req, k == 0);
            end
        end
        stalled_i = '0;
        clear_logs();
        repeat (9) tick();
        n_checks++;
        if (dpc_q.size() < 4) begin
            n_fail++;
            $display("FAIL stall_resume_count: delivered %0d words, required at least 4", dpc_q.size());
        end
        for (int i = 0; i < dpc_q.size(); i++) begin
            n_checks++;
            if (dpc_q[i] !== 32'(12 + 4 * i)) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: pc=%h, required %h", i, dpc_q[i], 32'(12 + 4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(3, 1'b1);
        repeat (2) tick();
        ex_branch_flag_i = 1'b1;
        ex_branch_addr_i = 32'h0000_0100;
        tick();
        n_checks++;
        if ({s_req, s_valid, s_pc, s_inst} !== 66'd0) begin
            n_fail++;
            $display("FAIL redirect_bubble: req=%b valid=%b pc=%h inst=%h, required all zero",
                     s_req, s_valid, s_pc, s_inst);
        end
        ex_branch_flag_i = 1'b0;
        clear_logs();
        for (int k = 0; k < 20 && dpc_q.size() < 2; k++) tick();
        n_checks++;
        if (dpc_q.size() < 2) begin
            n_fail++;
            $display("FAIL redirect_timeout: delivered %0d words, required 2", dpc_q.size());
        end else begin
            n_checks++;
            if (dpc_q[0] !== 32'h100 || dinst_q[0] !== 32'hA5A5_0100 || dpc_q[1] !== 32'h104) begin
                n_fail++;
                $display("FAIL redirect_words: pc0=%h inst0=%h pc1=%h, required 00000100 a5a50100 00000104",
                         dpc_q[0], dinst_q[0], dpc_q[1]);
            end
        end
        n_checks++;
        if (iss_q.size() == 0 || iss_q[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_addr: first issued %h, required 00000100",
                     iss_q.size() == 0 ? 32'hx : iss_q[0]);
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset(2, 1'b1);
        repeat (2) tick();
        ex_branch_flag_i = 1'b1;
        ex_branch_addr_i = 32'h0000_0200;
        tick();
        n_checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_rv_branch: req=%b valid=%b, required 0 0", s_req, s_valid);
        end
        ex_branch_flag_i = 1'b0;
        clear_logs();
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_rv_next_req: req=%b addr=%h, required 1 00000200", s_req, s_addr);
        end
        for (int k = 0; k < 20 && dpc_q.size() < 1; k++) tick();
        n_checks++;
        if (dpc_q.size() < 1 || dpc_q[0] !== 32'h200 || dinst_q[0] !== 32'hA5A5_0200) begin
            n_fail++;
            $display("FAIL redir_rv_word: pc=%h inst=%h, required 00000200 a5a50200",
                     dpc_q.size() == 0 ? 32'hx : dpc_q[0], dinst_q.size() == 0 ? 32'hx : dinst_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(3, 1'b1);
        repeat (2) tick();
        ex_branch_flag_i = 1'b1;
        ex_branch_addr_i = 32'h0000_0300;
        tick();
        ex_branch_addr_i = 32'h0000_0400;
        tick();
        ex_branch_flag_i = 1'b0;
        clear_logs();
        for (int k = 0; k < 20 && dpc_q.size() < 1; k++) tick();
        n_checks++;
        if (dpc_q.size() < 1 || dpc_q[0] !== 32'h400 || dinst_q[0] !== 32'hA5A5_0400) begin
            n_fail++;
            $display("FAIL b2b_word: pc=%h inst=%h, required 00000400 a5a50400",
                     dpc_q.size() == 0 ? 32'hx : dpc_q[0], dinst_q.size() == 0 ? 32'hx : dinst_q[0]);
        end
        n_checks++;
        if (iss_q.size() == 0 || iss_q[0] !== 32'h400) begin
            n_fail++;
            $display("FAIL b2b_addr: first issued %h, required 00000400",
                     iss_q.size() == 0 ? 32'hx : iss_q[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b1);
        tick();
        ex_branch_flag_i = 1'b1;
        ex_branch_addr_i = 32'hFFFF_FFFC;
        tick();
        ex_branch_flag_i = 1'b0;
        clear_logs();
        for (int k = 0; k < 20 && dpc_q.size() < 2; k++) tick();
        n_checks++;
        if (iss_q.size() < 2 || iss_q[0] !== 32'hFFFF_FFFC || iss_q[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: issued %0d addrs, first=%h, required fffffffc then 00000000",
                     iss_q.size(), iss_q.size() == 0 ? 32'hx : iss_q[0]);
        end
        n_checks++;
        if (dpc_q.size() < 2 || dpc_q[0] !== 32'hFFFF_FFFC || dinst_q[0] !== 32'h5A5A_FFFC ||
            dpc_q[1] !== 32'h0 || dinst_q[1] !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL wrap_words: delivered %0d words, first pc=%h, required fffffffc/5a5afffc then 0/a5a50000",
                     dpc_q.size(), dpc_q.size() == 0 ? 32'hx : dpc_q[0]);
        end
    endtask

    task automatic test_gnt_hold();
        do_reset(1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gnt_hold[%0d]: req=%b addr=%h valid=%b, required 1 00000000 0",
                         k, s_req, s_addr, s_valid);
            end
        end
        ibus_gnt_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_hold_latency: valid=%b one cycle after gnt, required 0", s_valid);
        end
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_inst !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL gnt_hold_data: valid=%b pc=%h inst=%h, required 1 00000000 a5a50000",
                     s_valid, s_pc, s_inst);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_back_to_back();
        test_wrap();
        test_gnt_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
